// File: rtl/mc_mem_pkg.sv
// mc_mem_pkg: shared types and constants for the multicycle MIPS memory unit.
//   state_t     - handshake FSM states (IDLE / WAIT / DONE)
//   err_cause_t - why a request was rejected; kept internally for debug
//   WORD_W      - data word width
//   classify()  - evaluates the error condition of a request at acceptance
package mc_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ALIGN    = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_CONFLICT = 2'd3
  } err_cause_t;

  // A conflicting read+write is reported first, then misalignment, then range.
  // Only one cause is recorded; any non-NONE cause makes the request an error.
  function automatic err_cause_t classify(input logic rd, input logic wr,
                                          input logic [WORD_W-1:0] addr,
                                          input int depth_words);
    err_cause_t cause;
    cause = ERR_NONE;
    if (rd && wr)
      cause = ERR_CONFLICT;
    else if (addr[1:0] != 2'b00)
      cause = ERR_ALIGN;
    else if (longint'(addr) >= 4 * longint'(depth_words))
      cause = ERR_RANGE;
    return cause;
  endfunction

endpackage

// File: rtl/mc_mem_if.sv
// mc_mem_if: request/response bundle between the multicycle datapath and
// the memory unit.
//   MemRead/MemWrite - request strobes from the control FSM
//   Addr             - byte address (from the IorD mux)
//   WriteData        - store data
//   ReadData         - registered read data
//   MemReady         - one-cycle completion pulse
//   MemBusy          - access in flight
//   MemErr           - one-cycle error pulse, coincident with MemReady
// master = core side, slave = memory side.
interface mc_mem_if;
  import mc_mem_pkg::*;

  logic              MemRead;
  logic              MemWrite;
  logic [WORD_W-1:0] Addr;
  logic [WORD_W-1:0] WriteData;
  logic [WORD_W-1:0] ReadData;
  logic              MemReady;
  logic              MemBusy;
  logic              MemErr;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, MemBusy, MemErr
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, MemReady, MemBusy, MemErr
  );
endinterface

// File: rtl/mc_mem_array.sv
// mc_mem_array: DEPTH_WORDS x WORD_W single-port storage, block-RAM style.
//   clk   - clock
//   we    - write enable (wdata -> mem[addr])
//   re    - read enable (mem[addr] -> rdata, registered)
//   addr  - word index
//   wdata - write data
//   rdata - registered read data; holds its value while re is low
// Contents are deliberately not reset.
import mc_mem_pkg::*;

module mc_mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mc_mem_unit.sv
// mc_mem_unit: unified instruction/data memory for the multicycle MIPS core,
// with a programmable wait-state latency and a ready handshake.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - mc_mem_if.slave (MemRead, MemWrite, Addr, WriteData in;
//           ReadData, MemReady, MemBusy, MemErr out)
// A request is accepted in IDLE, optionally waits WAIT_CYCLES cycles in WAIT,
// and completes in DONE (MemReady pulse). The array is accessed on the edge
// that enters DONE, so an access aborted by reset never touches the array.
import mc_mem_pkg::*;

module mc_mem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  mc_mem_if.slave bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [AW-1:0]     idx_reg;
  logic [WORD_W-1:0] wdata_reg;
  logic              rd_reg, wr_reg;
  err_cause_t        cause_reg;
  // ReadData shows the array output only after a successful read; reset and
  // errors force it to zero without touching the array's read register.
  logic              rd_valid_reg;

  logic              accept;
  err_cause_t        cause_in;
  logic              cur_rd, cur_wr, cur_err;
  logic [AW-1:0]     cur_idx;
  logic [WORD_W-1:0] cur_wdata;
  logic              entering_done;
  logic              mem_we, mem_re;
  logic [WORD_W-1:0] mem_rdata;

  assign accept   = (state_reg == IDLE) && (bus.MemRead || bus.MemWrite);
  assign cause_in = classify(bus.MemRead, bus.MemWrite, bus.Addr, DEPTH_WORDS);

  // With zero wait states the acceptance edge is also the edge entering DONE,
  // so the array must be driven from the live request in IDLE and from the
  // latched copy otherwise.
  always_comb begin
    if (state_reg == IDLE) begin
      cur_rd    = bus.MemRead;
      cur_wr    = bus.MemWrite;
      cur_err   = (cause_in != ERR_NONE);
      cur_idx   = bus.Addr[AW+1:2];
      cur_wdata = bus.WriteData;
    end else begin
      cur_rd    = rd_reg;
      cur_wr    = wr_reg;
      cur_err   = (cause_reg != ERR_NONE);
      cur_idx   = idx_reg;
      cur_wdata = wdata_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = DONE;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0)
          state_next = DONE;
        else
          cnt_next = cnt_reg - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign entering_done = (state_next == DONE) && (state_reg != DONE);
  assign mem_we        = entering_done && cur_wr && !cur_err;
  assign mem_re        = entering_done && cur_rd && !cur_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      cause_reg    <= ERR_NONE;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg   <= bus.Addr[AW+1:2];
        wdata_reg <= bus.WriteData;
        rd_reg    <= bus.MemRead;
        wr_reg    <= bus.MemWrite;
        cause_reg <= cause_in;
      end
      if (entering_done) begin
        if (cur_err)
          rd_valid_reg <= 1'b0;
        else if (cur_rd)
          rd_valid_reg <= 1'b1;
      end
    end
  end

  mc_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

  assign bus.ReadData = rd_valid_reg ? mem_rdata : '0;
  assign bus.MemReady = (state_reg == DONE);
  assign bus.MemBusy  = (state_reg != IDLE);
  assign bus.MemErr   = (state_reg == DONE) && (cause_reg != ERR_NONE);

endmodule
